// File: rtl/score_hex_display_if.sv
// ---------------------------------------------------------------------------
// score_hex_display_if
//
// Groups the score inputs and the four seven-segment outputs of
// score_hex_display into one bundle.
//
//   score_a, score_b   7-bit unsigned player scores (from the Nios exports)
//   hex_a1, hex_a0     player A tens / units digit, active-low segments
//   hex_b1, hex_b0     player B tens / units digit, active-low segments
//   busy               BCD converter is working on a value
//
// Modports:
//   master  drives the scores, observes the digits (system / testbench side)
//   slave   the display block itself
// ---------------------------------------------------------------------------
interface score_hex_display_if;
    logic [6:0] score_a;
    logic [6:0] score_b;
    logic [6:0] hex_a1;
    logic [6:0] hex_a0;
    logic [6:0] hex_b1;
    logic [6:0] hex_b0;
    logic       busy;

    modport master (
        output score_a, score_b,
        input  hex_a1, hex_a0, hex_b1, hex_b0, busy
    );

    modport slave (
        input  score_a, score_b,
        output hex_a1, hex_a0, hex_b1, hex_b0, busy
    );
endinterface

// File: rtl/score_hex_display.sv
// ---------------------------------------------------------------------------
// score_hex_display
//
// Converts two 7-bit player scores into four DE2-115 seven-segment digits
// (tens + units per player) using a single shared shift-add-3 converter
// that serves the players round-robin. A player's digits blink for
// BLINK_TOGGLES half-periods of BLINK_HALF cycles after every change.
// Values 100..127 are shown as two dashes.
//
// Ports:
//   clk_clk      system clock
//   reset_reset  synchronous, active-high reset
//   bus          score_hex_display_if.slave (scores in, digits/busy out)
//
// Parameters:
//   BLINK_HALF     clock cycles per blink half-period (>= 1)
//   BLINK_TOGGLES  half-periods per blink burst (even, >= 2)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is shown blank.
// ---------------------------------------------------------------------------
module score_hex_display #(
    parameter int unsigned BLINK_HALF    = 12500000,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    score_hex_display_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = SEG_BLANK;
`else
    localparam logic [6:0] TENS_ZERO = SEG_ZERO;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // A burst starts with an even toggle count and blanks first, so the
    // digits are hidden whenever the remaining count is even and nonzero.
    function automatic logic [13:0] show(input logic hund_nz, input logic [3:0] tens,
                                         input logic [3:0] units, input logic [31:0] tog);
        logic [13:0] r;
        if (tog != 32'd0 && !tog[0])
            r = {SEG_BLANK, SEG_BLANK};
        else if (hund_nz)
            r = {SEG_DASH, SEG_DASH};
        else
            r = {(tens == 4'd0) ? TENS_ZERO : glyph(tens), glyph(units)};
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  a_q, a_d, b_q, b_d;
    logic [6:0]  last_a_q, last_a_d, last_b_q, last_b_d;
    logic        sel_b_q, sel_b_d;
    logic        b_last_q, b_last_d;
    logic [6:0]  val_q, val_d;
    logic [6:0]  bin_q, bin_d;
    logic [9:0]  bcd_q, bcd_d;
    logic [9:0]  bcd_adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        hnz_a_q, hnz_a_d, hnz_b_q, hnz_b_d;
    logic [3:0]  tens_a_q, tens_a_d, units_a_q, units_a_d;
    logic [3:0]  tens_b_q, tens_b_d, units_b_q, units_b_d;
    logic [31:0] half_a_q, half_a_d, tog_a_q, tog_a_d;
    logic [31:0] half_b_q, half_b_d, tog_b_q, tog_b_d;
    logic [13:0] hex_a_q, hex_a_d, hex_b_q, hex_b_d;
    logic        pend_a, pend_b;

    // Input sampling, arbitration, the double-dabble datapath, blink timing
    // and the registered digit outputs are all computed here.
    always_comb begin
        state_d   = state_q;
        a_d       = bus.score_a;
        b_d       = bus.score_b;
        last_a_d  = last_a_q;
        last_b_d  = last_b_q;
        sel_b_d   = sel_b_q;
        b_last_d  = b_last_q;
        val_d     = val_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bcd_adj   = bcd_q;
        cnt_d     = cnt_q;
        hnz_a_d   = hnz_a_q;
        tens_a_d  = tens_a_q;
        units_a_d = units_a_q;
        hnz_b_d   = hnz_b_q;
        tens_b_d  = tens_b_q;
        units_b_d = units_b_q;
        half_a_d  = half_a_q;
        tog_a_d   = tog_a_q;
        half_b_d  = half_b_q;
        tog_b_d   = tog_b_q;

        pend_a = (a_q != last_a_q);
        pend_b = (b_q != last_b_q);

        if (tog_a_q != 32'd0) begin
            if (half_a_q == 32'd1) begin
                half_a_d = BLINK_HALF;
                tog_a_d  = tog_a_q - 32'd1;
            end else begin
                half_a_d = half_a_q - 32'd1;
            end
        end
        if (tog_b_q != 32'd0) begin
            if (half_b_q == 32'd1) begin
                half_b_d = BLINK_HALF;
                tog_b_d  = tog_b_q - 32'd1;
            end else begin
                half_b_d = half_b_q - 32'd1;
            end
        end

        case (state_q)
            IDLE: begin
                // On a tie, A wins only if B was the last player served.
                if (pend_a && (!pend_b || b_last_q)) begin
                    sel_b_d = 1'b0;
                    val_d   = a_q;
                    bin_d   = a_q;
                    bcd_d   = 10'd0;
                    cnt_d   = 3'd7;
                    state_d = SHIFT;
                end else if (pend_b) begin
                    sel_b_d = 1'b1;
                    val_d   = b_q;
                    bin_d   = b_q;
                    bcd_d   = 10'd0;
                    cnt_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The hundreds digit never exceeds 1, so only tens/units need the add-3.
                if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
                if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = STORE;
            end
            STORE: begin
                if (sel_b_q) begin
                    hnz_b_d   = |bcd_q[9:8];
                    tens_b_d  = bcd_q[7:4];
                    units_b_d = bcd_q[3:0];
                    last_b_d  = val_q;
                    half_b_d  = BLINK_HALF;
                    tog_b_d   = BLINK_TOGGLES;
                end else begin
                    hnz_a_d   = |bcd_q[9:8];
                    tens_a_d  = bcd_q[7:4];
                    units_a_d = bcd_q[3:0];
                    last_a_d  = val_q;
                    half_a_d  = BLINK_HALF;
                    tog_a_d   = BLINK_TOGGLES;
                end
                b_last_d = sel_b_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        hex_a_d = show(hnz_a_q, tens_a_q, units_a_q, tog_a_q);
        hex_b_d = show(hnz_b_q, tens_b_q, units_b_q, tog_b_q);
    end

    // State register; reset abandons any conversion in flight and puts the
    // display back to showing zero for both players.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            a_q       <= 7'd0;
            b_q       <= 7'd0;
            last_a_q  <= 7'd0;
            last_b_q  <= 7'd0;
            sel_b_q   <= 1'b0;
            b_last_q  <= 1'b1;
            val_q     <= 7'd0;
            bin_q     <= 7'd0;
            bcd_q     <= 10'd0;
            cnt_q     <= 3'd0;
            hnz_a_q   <= 1'b0;
            tens_a_q  <= 4'd0;
            units_a_q <= 4'd0;
            hnz_b_q   <= 1'b0;
            tens_b_q  <= 4'd0;
            units_b_q <= 4'd0;
            half_a_q  <= 32'd0;
            tog_a_q   <= 32'd0;
            half_b_q  <= 32'd0;
            tog_b_q   <= 32'd0;
            hex_a_q   <= {TENS_ZERO, SEG_ZERO};
            hex_b_q   <= {TENS_ZERO, SEG_ZERO};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            last_a_q  <= last_a_d;
            last_b_q  <= last_b_d;
            sel_b_q   <= sel_b_d;
            b_last_q  <= b_last_d;
            val_q     <= val_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            hnz_a_q   <= hnz_a_d;
            tens_a_q  <= tens_a_d;
            units_a_q <= units_a_d;
            hnz_b_q   <= hnz_b_d;
            tens_b_q  <= tens_b_d;
            units_b_q <= units_b_d;
            half_a_q  <= half_a_d;
            tog_a_q   <= tog_a_d;
            half_b_q  <= half_b_d;
            tog_b_q   <= tog_b_d;
            hex_a_q   <= hex_a_d;
            hex_b_q   <= hex_b_d;
        end
    end

    assign bus.hex_a1 = hex_a_q[13:7];
    assign bus.hex_a0 = hex_a_q[6:0];
    assign bus.hex_b1 = hex_b_q[13:7];
    assign bus.hex_b0 = hex_b_q[6:0];
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_score_hex_display.sv
// ---------------------------------------------------------------------------
// tb_score_hex_display
//
// Directed bench for score_hex_display with a short blink (4 cycles per
// half-period, 4 half-periods per burst). Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edges.
// ---------------------------------------------------------------------------
module tb_score_hex_display;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DA = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TZ = 7'h7F;
`else
    localparam logic [6:0] TZ = 7'h40;
`endif

    logic clk_clk = 1'b0;
    logic reset_reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    score_hex_display_if bus();

    score_hex_display #(.BLINK_HALF(4), .BLINK_TOGGLES(4)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;

    // Advance past one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk_clk);
        @(negedge clk_clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        bus.score_a = 7'd0;
        bus.score_b = 7'd0;
        ticks(3);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0} !== {TZ, 7'h40, TZ, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL reset_hex: got %h %h %h %h want %h 40 %h 40",
                     bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0, TZ, TZ);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
        end
        reset_reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (bus.busy !== 1'b0 ||
                {bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0} !== {TZ, 7'h40, TZ, 7'h40}) begin
                n_fail++;
                $display("[TB] FAIL idle_zero cycle %0d: got busy %b hex %h %h %h %h want busy 0 hex %h 40 %h 40",
                         i, bus.busy, bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0, TZ, TZ);
            end
        end
    endtask

    task automatic test_convert_blink();
        logic [13:0] exp_a;
        bus.score_a = 7'd42;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_after_k: got %b want 0", bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_after_k1: got %b want 1", bus.busy);
        end
        ticks(8);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0} !== {TZ, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL a_before_update: got %h %h want %h 40", bus.hex_a1, bus.hex_a0, TZ);
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            exp_a = ((i / 4) == 0 || (i / 4) == 2) ? {BL, BL} : {7'h19, 7'h24};
            n_cmp++;
            if ({bus.hex_a1, bus.hex_a0} !== exp_a) begin
                n_fail++;
                $display("[TB] FAIL blink_42 step %0d: got %h %h want %h %h",
                         i, bus.hex_a1, bus.hex_a0, exp_a[13:7], exp_a[6:0]);
            end
            n_cmp++;
            if ({bus.hex_b1, bus.hex_b0} !== {TZ, 7'h40}) begin
                n_fail++;
                $display("[TB] FAIL b_untouched step %0d: got %h %h want %h 40",
                         i, bus.hex_b1, bus.hex_b0, TZ);
            end
        end
    endtask

    task automatic test_simultaneous();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        bus.score_a = 7'd99;
        bus.score_b = 7'd7;
        ticks(11);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0} !== {BL, BL, TZ, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL sim_a_blank: got %h %h %h %h want 7f 7f %h 40",
                     bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0, TZ);
        end
        ticks(4);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0} !== {7'h10, 7'h10, TZ, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL sim_a_99: got %h %h %h %h want 10 10 %h 40",
                     bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0, TZ);
        end
        ticks(4);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {TZ, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL sim_b_not_yet: got %h %h want %h 40", bus.hex_b1, bus.hex_b0, TZ);
        end
        tick();
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {BL, BL}) begin
            n_fail++;
            $display("[TB] FAIL sim_b_blank: got %h %h want 7f 7f", bus.hex_b1, bus.hex_b0);
        end
        ticks(4);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {TZ, 7'h78}) begin
            n_fail++;
            $display("[TB] FAIL sim_b_7: got %h %h want %h 78", bus.hex_b1, bus.hex_b0, TZ);
        end
    endtask

    task automatic test_dash();
        ticks(30);
        bus.score_b = 7'd100;
        ticks(15);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {DA, DA}) begin
            n_fail++;
            $display("[TB] FAIL dash_100: got %h %h want 3f 3f", bus.hex_b1, bus.hex_b0);
        end
        ticks(16);
        bus.score_b = 7'd127;
        ticks(15);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {DA, DA}) begin
            n_fail++;
            $display("[TB] FAIL dash_127: got %h %h want 3f 3f", bus.hex_b1, bus.hex_b0);
        end
        ticks(16);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {DA, DA}) begin
            n_fail++;
            $display("[TB] FAIL dash_127_steady: got %h %h want 3f 3f", bus.hex_b1, bus.hex_b0);
        end
        bus.score_b = 7'd5;
        ticks(11);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {BL, BL}) begin
            n_fail++;
            $display("[TB] FAIL b5_blank: got %h %h want 7f 7f", bus.hex_b1, bus.hex_b0);
        end
        ticks(4);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {TZ, 7'h12}) begin
            n_fail++;
            $display("[TB] FAIL b5_shown: got %h %h want %h 12", bus.hex_b1, bus.hex_b0, TZ);
        end
        ticks(16);
        n_cmp++;
        if ({bus.hex_b1, bus.hex_b0} !== {TZ, 7'h12}) begin
            n_fail++;
            $display("[TB] FAIL b5_steady: got %h %h want %h 12", bus.hex_b1, bus.hex_b0, TZ);
        end
    endtask

    task automatic test_restart();
        bus.score_a = 7'd3;
        ticks(15);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0} !== {TZ, 7'h30}) begin
            n_fail++;
            $display("[TB] FAIL a3_shown: got %h %h want %h 30", bus.hex_a1, bus.hex_a0, TZ);
        end
        bus.score_a = 7'd8;
        ticks(11);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0} !== {BL, BL}) begin
            n_fail++;
            $display("[TB] FAIL a8_restart_blank: got %h %h want 7f 7f", bus.hex_a1, bus.hex_a0);
        end
        ticks(4);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0} !== {TZ, 7'h00}) begin
            n_fail++;
            $display("[TB] FAIL a8_shown: got %h %h want %h 00", bus.hex_a1, bus.hex_a0, TZ);
        end
        ticks(4);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0} !== {BL, BL}) begin
            n_fail++;
            $display("[TB] FAIL a8_full_burst: got %h %h want 7f 7f", bus.hex_a1, bus.hex_a0);
        end
    endtask

    task automatic test_reset_mid_shift();
        ticks(30);
        bus.score_a = 7'd50;
        ticks(4);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL shift_busy: got %b want 1", bus.busy);
        end
        reset_reset = 1'b1;
        tick();
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0} !== {TZ, 7'h40, TZ, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL midreset_hex: got %h %h %h %h want %h 40 %h 40",
                     bus.hex_a1, bus.hex_a0, bus.hex_b1, bus.hex_b0, TZ, TZ);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_busy: got %b want 0", bus.busy);
        end
        reset_reset = 1'b0;
        ticks(15);
        n_cmp++;
        if ({bus.hex_a1, bus.hex_a0} !== {7'h12, 7'h40}) begin
            n_fail++;
            $display("[TB] FAIL after_reset_50: got %h %h want 12 40", bus.hex_a1, bus.hex_a0);
        end
    endtask

    initial begin
        reset_reset = 1'b1;
        bus.score_a = 7'd0;
        bus.score_b = 7'd0;
        @(negedge clk_clk);
        test_reset();
        test_convert_blink();
        test_simultaneous();
        test_dash();
        test_restart();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
